skolem_sweep_checker: RTL and testbench

Sequential exhaustive checker for the 4-bit Skolem witness function of `find_inv bvsle bvlshr0`, where x is the shifted operand: find x such that `(x >>u s) <=s t`.
- Sits directly downstream of the combinational Skolem block: drives its (s, t) inputs, samples its witness x, and independently brute-forces whether any x exists.
- Flags every (s, t) pair where a solution exists but the returned witness does not satisfy the constraint.
- Used as the sign-off stage for generated Skolem netlists in simulation and FPGA bring-up.

---
 rtl/skolem_chk_pkg.sv | 34 +++
 rtl/skolem_sweep_checker_cond.sv | 15 +
 rtl/skolem_sweep_checker.sv | 133 +++++++++++++
 tb/tb_skolem_sweep_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem sweep checker: FSM states, default width,
// and the inverse-constraint predicate used by both the witness and the
// candidate checks.
package skolem_chk_pkg;

   localparam int W_DEF = 4;

   // Widest operand the predicate is written for; callers zero-extend.
   localparam int MAX_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SEARCH,
      ST_JUDGE,
      ST_DONE
   } state_t;

   // cond(x,s,t) = $signed(x >>u s) <= $signed(t) at width w.
   // Operands arrive zero-extended from w bits. The signed compare is done
   // by flipping bit w-1 of both sides, which maps w-bit two's complement
   // order onto unsigned order. Any s >= w shifts x to zero naturally.
   function automatic logic inv_cond(input logic [MAX_W-1:0] x,
                                     input logic [MAX_W-1:0] s,
                                     input logic [MAX_W-1:0] t,
                                     input int               w);
      logic [MAX_W-1:0] sh;
      logic [MAX_W-1:0] msb;
      sh  = x >> s;
      msb = MAX_W'(1) << (w - 1);
      return ((sh ^ msb) <= (t ^ msb));
   endfunction

endpackage

// File: rtl/skolem_sweep_checker_cond.sv
// Combinational wrapper around inv_cond at a fixed operand width.
module skolem_inv_cond
   import skolem_chk_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
   output logic         ok
);

   assign ok = inv_cond(MAX_W'(x), MAX_W'(s), MAX_W'(t), W);

endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sign-off checker for the find_inv bvsle bvlshr0 Skolem block.
// Walks every (s,t) pair, samples the block's witness in APPLY, then
// brute-forces all candidates x to learn whether any solution exists, and
// records pairs where a solution exists but the witness misses it.
module skolem_sweep_checker
   import skolem_chk_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   output logic [W-1:0]   sk_s,
   output logic [W-1:0]   sk_t,
   input  logic [W-1:0]   sk_x,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [2*W:0]   fail_count,
   output logic [2*W:0]   unsat_count,
   output logic           first_fail_valid,
   output logic [W-1:0]   first_fail_s,
   output logic [W-1:0]   first_fail_t
);

   state_t         state;
   logic [2*W-1:0] idx;
   logic [W-1:0]   cand;
   logic           wit_ok;
   logic           exists;
   logic           wit_cond;
   logic           cand_cond;
   logic           fail_hit;

   // Operands come straight from the registered pair index, s fastest.
   assign sk_s = idx[W-1:0];
   assign sk_t = idx[2*W-1:W];

   // Witness check: the Skolem block answers combinationally in APPLY.
   skolem_inv_cond #(.W(W)) u_wit_cond (
      .x  (sk_x),
      .s  (sk_s),
      .t  (sk_t),
      .ok (wit_cond)
   );

   // Candidate check: one x per SEARCH cycle.
   skolem_inv_cond #(.W(W)) u_cand_cond (
      .x  (cand),
      .s  (sk_s),
      .t  (sk_t),
      .ok (cand_cond)
   );

   // Unsat pairs are never failures, whatever the witness returned.
   assign fail_hit = exists & ~wit_ok;

   // Sweep FSM with index/candidate counters and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         idx              <= '0;
         cand             <= '0;
         wit_ok           <= 1'b0;
         exists           <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         fail_count       <= '0;
         unsat_count      <= '0;
         first_fail_valid <= 1'b0;
         first_fail_s     <= '0;
         first_fail_t     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  idx              <= '0;
                  busy             <= 1'b1;
                  pass             <= 1'b0;
                  fail_count       <= '0;
                  unsat_count      <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_s     <= '0;
                  first_fail_t     <= '0;
                  state            <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               wit_ok <= wit_cond;
               exists <= 1'b0;
               cand   <= '0;
               state  <= ST_SEARCH;
            end
            ST_SEARCH: begin
               // No early exit: every pair costs the same number of cycles.
               exists <= exists | cand_cond;
               cand   <= cand + 1'b1;
               if (&cand)
                  state <= ST_JUDGE;
            end
            ST_JUDGE: begin
               if (!exists)
                  unsat_count <= unsat_count + 1'b1;
               if (fail_hit) begin
                  fail_count <= fail_count + 1'b1;
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_s     <= sk_s;
                     first_fail_t     <= sk_t;
                  end
               end
               if (&idx) begin
                  // Fold in this pair's result, the count is not updated yet.
                  pass  <= (fail_count == '0) && !fail_hit;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_APPLY;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Self-checking bench for skolem_sweep_checker with a behavioural Skolem block
// (reference, stuck-at-0 and stuck-at-15 witnesses) and a brute-force golden.
module tb_skolem_sweep_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] sk_s, sk_t, sk_x;
   logic       busy, done, pass;
   logic [8:0] fail_count, unsat_count;
   logic       first_fail_valid;
   logic [3:0] first_fail_s, first_fail_t;

   int mode_sel = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         fail;
      int         unsat;
      bit         ffv;
      logic [3:0] ffs;
      logic [3:0] fft;
      bit         pass;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   skolem_sweep_checker #(.W(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .sk_s             (sk_s),
      .sk_t             (sk_t),
      .sk_x             (sk_x),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .fail_count       (fail_count),
      .unsat_count      (unsat_count),
      .first_fail_valid (first_fail_valid),
      .first_fail_s     (first_fail_s),
      .first_fail_t     (first_fail_t)
   );

   // Behavioural Skolem block under test.
   always_comb begin
      case (mode_sel)
         0:       sk_x = (sk_s == 4'd0) ? 4'b1000 : 4'b0000;
         1:       sk_x = 4'b0000;
         default: sk_x = 4'b1111;
      endcase
   end

   function automatic bit ref_cond(input logic [3:0] x, input logic [3:0] s,
                                   input logic [3:0] t);
      logic [3:0] sh;
      sh = x >> s;
      return $signed(sh) <= $signed(t);
   endfunction

   function automatic logic [3:0] model_x(input int mode, input logic [3:0] s);
      if (mode == 0) return (s == 4'd0) ? 4'b1000 : 4'b0000;
      if (mode == 1) return 4'b0000;
      return 4'b1111;
   endfunction

   function automatic exp_t golden(input int mode);
      exp_t e;
      logic [3:0] s, t;
      bit ex;
      e.fail = 0; e.unsat = 0; e.ffv = 0; e.ffs = 0; e.fft = 0;
      for (int ti = 0; ti < 16; ti++) begin
         for (int si = 0; si < 16; si++) begin
            s = si[3:0];
            t = ti[3:0];
            ex = 0;
            for (int xi = 0; xi < 16; xi++)
               if (ref_cond(xi[3:0], s, t)) ex = 1;
            if (!ex) e.unsat++;
            else if (!ref_cond(model_x(mode, s), s, t)) begin
               e.fail++;
               if (!e.ffv) begin
                  e.ffv = 1; e.ffs = s; e.fft = t;
               end
            end
         end
      end
      e.pass = (e.fail == 0);
      return e;
   endfunction

   task automatic start_sweep(input int mode, input bit hold);
      mode_sel = mode;
      q.push_back(golden(mode));
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Wait for done (bounded), check timing/ordering, pop and compare results.
   task automatic finish_sweep(input int n0);
      int n;
      int p;
      bit got;
      int busy_bad;
      int ord_bad;
      exp_t e;
      n = n0; got = 0; busy_bad = 0; ord_bad = 0;
      while (!got && n < 6000) begin
         @(negedge clk);
         n++;
         if (done) got = 1;
         else begin
            if (!busy) busy_bad++;
            if (n <= 4608 && ((n - 1) % 18) == 0) begin
               p = (n - 1) / 18;
               if ({sk_t, sk_s} !== p[7:0]) ord_bad++;
            end
         end
      end
      start = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL timeout: no done after %0d cycles, required done", n);
         void'(q.pop_front());
         return;
      end
      e = q.pop_front();
      checks++;
      if (n !== 4609) begin errors++; $display("FAIL sweep_len: got %0d required 4609", n); end
      checks++;
      if (busy_bad !== 0) begin errors++; $display("FAIL busy_window: %0d low cycles, required 0", busy_bad); end
      checks++;
      if (ord_bad !== 0) begin errors++; $display("FAIL pair_order: %0d bad APPLY operands, required 0", ord_bad); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b required 0", busy); end
      checks++;
      if (fail_count !== 9'(e.fail)) begin errors++; $display("FAIL fail_count: got %0d required %0d", fail_count, e.fail); end
      checks++;
      if (unsat_count !== 9'(e.unsat)) begin errors++; $display("FAIL unsat_count: got %0d required %0d", unsat_count, e.unsat); end
      checks++;
      if (first_fail_valid !== e.ffv) begin errors++; $display("FAIL ff_valid: got %b required %b", first_fail_valid, e.ffv); end
      checks++;
      if (first_fail_s !== e.ffs || first_fail_t !== e.fft) begin
         errors++;
         $display("FAIL ff_pair: got s=%0d t=%0d required s=%0d t=%0d", first_fail_s, first_fail_t, e.ffs, e.fft);
      end
      checks++;
      if (pass !== e.pass) begin errors++; $display("FAIL pass: got %b required %b", pass, e.pass); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || pass !== e.pass) begin
         errors++;
         $display("FAIL done_pulse: got done=%b pass=%b required done=0 pass=%b", done, pass, e.pass);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, pass, first_fail_valid} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 0000", {busy, done, pass, first_fail_valid});
      end
      checks++;
      if (fail_count !== 9'd0 || unsat_count !== 9'd0) begin
         errors++; $display("FAIL reset_counts: got %0d/%0d required 0/0", fail_count, unsat_count);
      end
      checks++;
      if ({sk_s, sk_t, first_fail_s, first_fail_t} !== 16'h0) begin
         errors++; $display("FAIL reset_operands: got %h required 0000", {sk_s, sk_t, first_fail_s, first_fail_t});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sweep_ref;
      start_sweep(0, 0);
      finish_sweep(0);
   endtask

   task automatic test_stuck0;
      start_sweep(1, 0);
      finish_sweep(0);
   endtask

   task automatic test_stuck15;
      start_sweep(2, 0);
      finish_sweep(0);
   endtask

   task automatic test_hold_start;
      int bad;
      bad = 0;
      start_sweep(0, 1);
      finish_sweep(0);
      repeat (5) begin
         @(negedge clk);
         if (busy || done) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL hold_start_rerun: %0d busy/done cycles after sweep, required 0", bad); end
   endtask

   task automatic test_back_to_back;
      start_sweep(0, 0);
      finish_sweep(0);
      start_sweep(1, 0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || pass !== 1'b0 || first_fail_valid !== 1'b0) begin
         errors++; $display("FAIL restart_flags: got busy=%b pass=%b ffv=%b required 1 0 0", busy, pass, first_fail_valid);
      end
      checks++;
      if (fail_count !== 9'd0 || unsat_count !== 9'd0) begin
         errors++; $display("FAIL restart_counts: got %0d/%0d required 0/0", fail_count, unsat_count);
      end
      finish_sweep(1);
   endtask

   task automatic test_reset_mid;
      int bad;
      bad = 0;
      start_sweep(0, 0);
      repeat (1999) @(negedge clk);
      start = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      void'(q.pop_front());
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
         errors++; $display("FAIL midreset_flags: got busy=%b done=%b pass=%b required 000", busy, done, pass);
      end
      checks++;
      if (fail_count !== 9'd0 || unsat_count !== 9'd0 || {sk_s, sk_t} !== 8'h0) begin
         errors++; $display("FAIL midreset_state: got %0d/%0d idx=%h required 0/0 idx=00", fail_count, unsat_count, {sk_t, sk_s});
      end
      rst_n = 1'b1;
      start = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (busy || done) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL midreset_idle: %0d busy/done cycles, required 0", bad); end
      start_sweep(2, 0);
      finish_sweep(0);
   endtask

   initial begin
      test_reset();
      test_sweep_ref();
      test_stuck0();
      test_stuck15();
      test_hold_start();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
